// File: rtl/multiplexer_n_to_1_rr_pkg.sv
// Shared constants for the registered N-to-1 stream mux.
// Mode encodings and the clog2 helper used to size channel indices.
package multiplexer_n_to_1_rr_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Index width for n channels; never below 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/multiplexer_n_to_1_rr_round_robin_arbiter.sv
// Combinational round-robin arbiter: scans req_i upward from ptr_i+1.
// Ports: req_i, ptr_i in; one-hot gnt_o, idx_o, any_o out.
module round_robin_arbiter
  import multiplexer_n_to_1_rr_pkg::*;
#(
  parameter  int NChannels = 4,
  localparam int SelBits   = clog2(NChannels)
) (
  input  logic [NChannels-1:0] req_i,
  input  logic [SelBits-1:0]   ptr_i,
  output logic [NChannels-1:0] gnt_o,
  output logic [SelBits-1:0]   idx_o,
  output logic                 any_o
);

  always_comb begin
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    // Last grantee gets lowest priority; wraps modulo NChannels.
    for (int k = 1; k <= NChannels; k++) begin
      c = (int'(ptr_i) + k) % NChannels;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        idx_o    = SelBits'(c);
        gnt_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiplexer_n_to_1_rr.sv
// Registered N-to-1 stream mux, explicit select or round-robin.
// Ports: clk, reset(n), Mode, Selector, MUX_* in, Out_* out, Out_Ready in.
module multiplexer_n_to_1_rr
  import multiplexer_n_to_1_rr_pkg::*;
#(
  parameter  int NBits     = 32,
  parameter  int NChannels = 4,
  localparam int SelBits   = clog2(NChannels)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Mode,
  input  logic [SelBits-1:0]         Selector,
  input  logic [NChannels-1:0]       MUX_Valid,
  input  logic [NChannels*NBits-1:0] MUX_Data,
  output logic [NChannels-1:0]       MUX_Ready,
  output logic [NBits-1:0]           MUX_Output,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [SelBits-1:0]         Out_Channel
);

  logic                 valid_q, valid_d;
  logic [NBits-1:0]     data_q, data_d;
  logic [SelBits-1:0]   chan_q, chan_d;
  logic [SelBits-1:0]   ptr_q, ptr_d;

  logic [NChannels-1:0] rr_gnt;
  logic [SelBits-1:0]   rr_idx;
  logic                 rr_any;

  logic [NChannels-1:0] sel_gnt;
  logic                 sel_any;

  logic [NChannels-1:0] gnt;
  logic [SelBits-1:0]   gnt_idx;
  logic                 gnt_any;
  logic                 free;

  round_robin_arbiter #(
    .NChannels(NChannels)
  ) u_arb (
    .req_i(MUX_Valid),
    .ptr_i(ptr_q),
    .gnt_o(rr_gnt),
    .idx_o(rr_idx),
    .any_o(rr_any)
  );

  // Selector values past the last channel never grant.
  always_comb begin
    sel_gnt = '0;
    sel_any = 1'b0;
    if (int'(Selector) < NChannels) begin
      if (MUX_Valid[Selector]) begin
        sel_any           = 1'b1;
        sel_gnt[Selector] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    unique case (Mode)
      MODE_SELECT: begin
        gnt     = sel_gnt;
        gnt_idx = Selector;
        gnt_any = sel_any;
      end
      MODE_RR: begin
        gnt     = rr_gnt;
        gnt_idx = rr_idx;
        gnt_any = rr_any;
      end
      default: ;
    endcase
  end

  // Pass-through ready: a consumed word frees the slot this cycle.
  assign free      = !valid_q || Out_Ready;
  assign MUX_Ready = (reset && free) ? gnt : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (free) begin
      valid_d = gnt_any;
      if (gnt_any) begin
        data_d = MUX_Data[int'(gnt_idx)*NBits +: NBits];
        chan_d = gnt_idx;
        ptr_d  = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= SelBits'(NChannels - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign MUX_Output  = data_q;
  assign Out_Valid   = valid_q;
  assign Out_Channel = chan_q;

endmodule

// File: tb/tb_multiplexer_n_to_1_rr.sv
// Scoreboard bench for multiplexer_n_to_1_rr (4-ch and 3-ch instances).
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_multiplexer_n_to_1_rr;

  localparam int N = 4;

  typedef struct {
    logic [31:0] d;
    int          ch;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mode = 1'b0;
  logic [1:0]    sel = '0;
  logic [N-1:0]  vld = '0;
  logic [31:0]   din [N];
  logic [N*32-1:0] mux_data;
  logic [N-1:0]  mux_rdy;
  logic [31:0]   out;
  logic          out_vld;
  logic          o_rdy = 1'b0;
  logic [1:0]    out_ch;

  logic          r3 = 1'b0;
  logic [1:0]    sel3 = '0;
  logic [2:0]    vld3 = '0;
  logic [95:0]   data3 = '0;
  logic [2:0]    rdy3;
  logic [31:0]   out3;
  logic          ov3;
  logic          ordy3 = 1'b0;
  logic [1:0]    och3;

  int total = 0;
  int bad   = 0;
  exp_t q[$];
  int   m_ptr = N - 1;
  bit   m_valid = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) mux_data[i*32 +: 32] = din[i];
  end

  multiplexer_n_to_1_rr #(.NBits(32), .NChannels(N)) dut (
    .clk(clk), .reset(reset), .Mode(mode), .Selector(sel),
    .MUX_Valid(vld), .MUX_Data(mux_data), .MUX_Ready(mux_rdy),
    .MUX_Output(out), .Out_Valid(out_vld), .Out_Ready(o_rdy),
    .Out_Channel(out_ch)
  );

  multiplexer_n_to_1_rr #(.NBits(32), .NChannels(3)) dut3 (
    .clk(clk), .reset(r3), .Mode(1'b0), .Selector(sel3),
    .MUX_Valid(vld3), .MUX_Data(data3), .MUX_Ready(rdy3),
    .MUX_Output(out3), .Out_Valid(ov3), .Out_Ready(ordy3),
    .Out_Channel(och3)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference grant from the rules: -1 means no grant.
  function automatic int exp_grant();
    if (mode == 1'b0) begin
      if (int'(sel) < N && vld[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      if (vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Inputs are driven at posedge+1; check ready, clock, update model.
  task automatic step();
    int g;
    bit fr;
    logic [N-1:0] er;
    #1;
    g  = exp_grant();
    fr = !m_valid || o_rdy;
    er = '0;
    if (g >= 0 && fr) er[g] = 1'b1;
    chk("mux_ready", 32'(mux_rdy), 32'(er));
    @(posedge clk);
    if (fr) begin
      if (g >= 0) begin
        q.push_back('{d: din[g], ch: g});
        m_ptr   = g;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_vld), 32'd0);
    chk("rst_output", out, 32'd0);
    chk("rst_channel", 32'(out_ch), 32'd0);
    chk("rst_mux_ready", 32'(mux_rdy), 32'd0);
    q.delete();
    m_valid = 1'b0;
    m_ptr   = N - 1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      total++;
      if (out_vld) begin
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_word: got valid %h ch%0d, expected none",
                   out, out_ch);
        end else begin
          if (out !== q[0].d || int'(out_ch) != q[0].ch) begin
            bad++;
            $display("FAIL sb_word: got %h ch%0d expected %h ch%0d",
                     out, out_ch, q[0].d, q[0].ch);
          end
          if (o_rdy) void'(q.pop_front());
        end
      end else if (q.size() != 0) begin
        bad++;
        $display("FAIL sb_valid: got Out_Valid=0 expected word %h",
                 q[0].d);
      end
    end
  end

  initial begin
    int seq [5];
    int sp  [3];
    logic [31:0] held;
    seq = '{0, 1, 2, 3, 0};
    sp  = '{3, 1, 3};
    for (int i = 0; i < N; i++) din[i] = 32'h0;

    @(posedge clk);
    #1;
    vld = 4'b1111;
    do_reset();

    // Explicit select of channel 2
    mode = 1'b0; sel = 2'd2; vld = 4'b0100;
    din[2] = 32'hDEADBEEF; o_rdy = 1'b1;
    step();
    chk("m0_out", out, 32'hDEADBEEF);
    chk("m0_ch", 32'(out_ch), 32'd2);
    chk("m0_valid", 32'(out_vld), 32'd1);

    // Fairness from reset
    vld = 4'b1111;
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_seq", 32'(out_ch), 32'(seq[i]));
    end

    // Backpressure holding 0x11111111 from ch1
    mode = 1'b0; sel = 2'd1; vld = 4'b0010;
    din[1] = 32'h11111111; o_rdy = 1'b1;
    step();
    o_rdy = 1'b0; mode = 1'b1; din[1] = 32'h22222222;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", out, 32'h11111111);
    end
    o_rdy = 1'b1;
    #1;
    chk("bp_pass_ready", 32'(mux_rdy), 32'b0010);
    step();
    chk("bp_new", out, 32'h22222222);

    // Sparse round-robin after ch1 grant
    vld = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sparse_seq", 32'(out_ch), 32'(sp[i]));
    end
    vld = 4'b0000;
    step();
    chk("idle_valid", 32'(out_vld), 32'd0);

    // Reset mid-hold
    mode = 1'b0; sel = 2'd0; vld = 4'b0001;
    din[0] = 32'hCAFEF00D;
    step();
    o_rdy = 1'b0;
    step();
    chk("hold_cafe", out, 32'hCAFEF00D);
    do_reset();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      mode  = 1'($urandom);
      sel   = 2'($urandom);
      vld   = 4'($urandom);
      o_rdy = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < N; c++) din[c] = $urandom;
      step();
    end
    vld = '0; o_rdy = 1'b1;
    repeat (3) step();
    chk("drain_queue", 32'(q.size()), 32'd0);

    // Three channels, selector past the end
    r3 = 1'b1; ordy3 = 1'b1; vld3 = 3'b111;
    data3 = {32'h33333333, 32'h22222222, 32'h11111111};
    sel3 = 2'd0;
    @(posedge clk);
    #1;
    chk("n3_valid", 32'(ov3), 32'd1);
    held = out3;
    chk("n3_word", held, 32'h11111111);
    sel3 = 2'd3;
    #1;
    chk("n3_ready_oor", 32'(rdy3), 32'd0);
    @(posedge clk);
    #1;
    chk("n3_drained", 32'(ov3), 32'd0);
    chk("n3_ready_oor2", 32'(rdy3), 32'd0);
    chk("n3_keep_word", out3, 32'h11111111);
    chk("n3_keep_ch", 32'(och3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplexer_n_to_1_rr.md
# multiplexer_n_to_1_rr

Registered N-to-1 stream multiplexer: the parametrised successor of the 2-to-1 datapath mux. It selects one of NChannels NBits-wide inputs and holds the word in an output register with a valid/ready handshake. Selection is either by an explicit selector or by round-robin arbitration among valid channels. It sits wherever several producers share one consumer across a clock boundary stage, e.g. write-back source selection with stall support.

## Interface
- NBits, 32, data width per channel
- NChannels, 4, number of input channels (≥2)
- SelBits (localparam), clog2(NChannels), selector/channel-index width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Mode  input  1  0 = explicit select, 1 = round-robin
- Selector  input  SelBits  channel index used in Mode 0
- MUX_Valid  input  NChannels  per-channel data valid
- MUX_Data  input  NChannels*NBits  flattened inputs; channel i at [i*NBits +: NBits]
- MUX_Ready  output  NChannels  one-hot accept; combinational
- MUX_Output  output  NBits  registered selected word
- Out_Valid  output  1  MUX_Output holds an unconsumed word
- Out_Ready  input  1  consumer accepts MUX_Output this cycle
- Out_Channel  output  SelBits  source channel of the held word

## Operation
- Slot free = !Out_Valid || Out_Ready. Two effective states: EMPTY (Out_Valid=0) and HOLD (Out_Valid=1).
- Mode 0 grant: channel Selector, only if Selector < NChannels and MUX_Valid[Selector]=1; otherwise no grant.
- Mode 1 grant: first channel with MUX_Valid=1 scanning upward from Pointer+1, wrapping modulo NChannels; none if MUX_Valid=0.
- MUX_Ready = grant one-hot AND free. At most one bit is set. It is never set for an invalid channel.
- Transfer occurs on a rising edge with a grant and free. MUX_Output <= granted data. Out_Channel <= granted index. Out_Valid <= 1. Pointer <= granted index. The Pointer updates in either mode.
- Free with no grant: Out_Valid <= 0. MUX_Output and Out_Channel keep their last values.
- HOLD with Out_Ready=0: all outputs are stable, MUX_Ready=0.
- A Mode or Selector change affects only the next grant. The held word is untouched.

## Timing
- Latency is 1 cycle from accepted input to MUX_Output/Out_Valid.
- Throughput is 1 word/cycle while Out_Ready=1. Out_Ready=1 on a HOLD cycle frees the slot in that same cycle (pass-through ready).
- MUX_Ready has a combinational path from MUX_Valid, Mode, Selector and Out_Ready. There is no combinational path from inputs to MUX_Output.
- Reset values: Out_Valid=0, MUX_Output=0, Out_Channel=0, Pointer=NChannels-1, so channel 0 has first round-robin priority. MUX_Ready=0 while reset is asserted.
- Reset asserted mid-operation clears immediately (asynchronously). A held word is discarded. The first grant is possible on the first rising edge after release.
- Round-robin wrap: if Pointer=NChannels-1, the scan starts at channel 0.
- Non-power-of-two NChannels: Selector values ≥ NChannels never grant.

## Structure
- Shared package/header: mode encodings MODE_SELECT=1'b0 and MODE_RR=1'b1, plus the clog2 constant function used for SelBits.
- One sub-module: round_robin_arbiter. It is combinational, takes a request vector and the pointer, and returns a one-hot grant and an index. The top level holds the Pointer and output registers, does Mode 0 selection and the handshake.

## Test plan
- Reset: mid-HOLD with MUX_Output=0xCAFEF00D, drive reset=0 between edges → Out_Valid=0, MUX_Output=0, Out_Channel=0 immediately, MUX_Ready=4'b0000.
- Mode 0: Selector=2, MUX_Valid=4'b0100, ch2=0xDEADBEEF, Out_Ready=1 → MUX_Ready=4'b0100 that cycle; next cycle MUX_Output=0xDEADBEEF, Out_Valid=1, Out_Channel=2.
- Mode 1 fairness: MUX_Valid=4'b1111, Out_Ready=1 for 5 cycles after reset → grants 0,1,2,3,0; Out_Channel sequence 0,1,2,3,0.
- Backpressure: hold 0x11111111, Out_Ready=0 for 3 cycles with ch1 valid → MUX_Ready=0 and outputs stable. Then Out_Ready=1 → MUX_Ready[1]=1 that same cycle, and the new word appears on the next cycle.
- Sparse round-robin: last grant ch1, MUX_Valid=4'b1010 → next grants 3, 1, 3. MUX_Valid=0 with Out_Ready=1 → Out_Valid falls next cycle.
- Out-of-range select: NChannels=3, Mode 0, Selector=3, MUX_Valid=3'b111 → MUX_Ready=3'b000; Out_Valid drops to 0 after the held word drains.
